// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing generator with sync/enable strobes and four built-in test patterns.
// Every output is registered and reflects the (h,v) counter state of the previous clock.
module video_timing_gen #(
    parameter int H_WIDTH  = 1920,
    parameter int H_START  = 2008,
    parameter int H_SYNC   = 44,
    parameter int H_TOTAL  = 2200,
    parameter int V_HEIGHT = 1080,
    parameter int V_START  = 1084,
    parameter int V_SYNC   = 5,
    parameter int V_TOTAL  = 1125,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    parameter int KH       = 30,
    parameter int KV       = 30
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    input  logic [1:0]  pat_i,
    output logic        hs_o,
    output logic        vs_o,
    output logic        de_o,
    output logic [23:0] data_o,
    output logic [11:0] x_o,
    output logic [11:0] y_o,
    output logic        sof_o
);
    localparam logic [12:0] HW  = 13'(H_WIDTH);
    localparam logic [12:0] HS0 = 13'(H_START);
    localparam logic [12:0] HS1 = 13'(H_START + H_SYNC);
    localparam logic [12:0] HT  = 13'(H_TOTAL - 1);
    localparam logic [12:0] VH  = 13'(V_HEIGHT);
    localparam logic [12:0] VS0 = 13'(V_START);
    localparam logic [12:0] VS1 = 13'(V_START + V_SYNC);
    localparam logic [12:0] VT  = 13'(V_TOTAL - 1);
    localparam logic [11:0] KH1 = 12'(KH - 1);
    localparam logic [11:0] KV1 = 12'(KV - 1);
    localparam int          BW  = H_WIDTH / 8;
    localparam logic [7:0][23:0] BARS = {
        24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
        24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
    };

    logic [11:0] r_h, r_v, r_kx, r_ky;
    logic        r_bx, r_by;
    logic [1:0]  r_pat;

    logic [12:0] w_h13, w_v13;
    logic        w_hwrap, w_vwrap, w_origin, w_de, w_hs, w_vs;
    logic [1:0]  w_pat;
    logic [2:0]  w_bar;
    logic [23:0] w_rgb;

    assign w_h13    = {1'b0, r_h};
    assign w_v13    = {1'b0, r_v};
    assign w_hwrap  = (w_h13 == HT);
    assign w_vwrap  = (w_v13 == VT);
    assign w_origin = (r_h == '0) && (r_v == '0);
    assign w_de     = (w_h13 < HW) && (w_v13 < VH);
    assign w_hs     = (w_h13 >= HS0) && (w_h13 < HS1);
    assign w_vs     = (w_v13 >= VS0) && (w_v13 < VS1);
    // The pixel at the frame origin already uses the newly selected pattern.
    assign w_pat    = w_origin ? pat_i : r_pat;

    // Bar index by threshold compare; pixels beyond the eighth bar stay on the last one.
    always_comb begin
        w_bar = '0;
        for (int i = 1; i < 8; i++)
            if (w_h13 >= 13'(i * BW)) w_bar = 3'(i);
        w_rgb = (w_pat == 2'd0) ? BARS[w_bar] :
                (w_pat == 2'd1) ? {24{~(r_bx ^ r_by)}} :
                (w_pat == 2'd2) ? {3{r_h[7:0]}} : 24'h808080;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_h   <= '0;
            r_v   <= '0;
            r_kx  <= '0;
            r_ky  <= '0;
            r_bx  <= 1'b0;
            r_by  <= 1'b0;
            r_pat <= '0;
        end else if (en_i) begin
            if (w_origin) r_pat <= pat_i;
            r_h <= w_hwrap ? '0 : r_h + 12'd1;
            if (w_hwrap) begin
                r_kx <= '0;
                r_bx <= 1'b0;
                r_v  <= w_vwrap ? '0 : r_v + 12'd1;
                if (w_vwrap) begin
                    r_ky <= '0;
                    r_by <= 1'b0;
                end else if (r_ky == KV1) begin
                    r_ky <= '0;
                    r_by <= ~r_by;
                end else begin
                    r_ky <= r_ky + 12'd1;
                end
            end else if (r_kx == KH1) begin
                r_kx <= '0;
                r_bx <= ~r_bx;
            end else begin
                r_kx <= r_kx + 12'd1;
            end
        end
    end

    // While frozen, x_o/y_o hold the last presented position.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            de_o   <= 1'b0;
            sof_o  <= 1'b0;
            data_o <= '0;
            x_o    <= '0;
            y_o    <= '0;
            hs_o   <= ~HS_POL;
            vs_o   <= ~VS_POL;
        end else if (!en_i) begin
            de_o   <= 1'b0;
            sof_o  <= 1'b0;
            data_o <= '0;
            hs_o   <= ~HS_POL;
            vs_o   <= ~VS_POL;
        end else begin
            de_o   <= w_de;
            sof_o  <= w_origin;
            data_o <= w_de ? w_rgb : '0;
            x_o    <= r_h;
            y_o    <= r_v;
            hs_o   <= w_hs ? HS_POL : ~HS_POL;
            vs_o   <= w_vs ? VS_POL : ~VS_POL;
        end
    end
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: directed stimulus for video_timing_gen on a small 14x7 raster,
// checked every cycle against an arithmetic raster model plus hand-computed literals.
module tb_video_timing_gen;
    localparam int HWID = 8, HST = 10, HSY = 2, HTOT = 14;
    localparam int VHEI = 4, VST = 5, VSY = 1, VTOT = 7, K = 2;

    logic        clk = 1'b0, rst_n = 1'b0, en = 1'b1;
    logic [1:0]  pat = 2'd0;
    logic        hs, vs, de, sof;
    logic [23:0] data;
    logic [11:0] x, y;

    int checks = 0, failures = 0;
    bit armed = 1'b0;

    video_timing_gen #(
        .H_WIDTH(HWID), .H_START(HST), .H_SYNC(HSY), .H_TOTAL(HTOT),
        .V_HEIGHT(VHEI), .V_START(VST), .V_SYNC(VSY), .V_TOTAL(VTOT),
        .HS_POL(1'b1), .VS_POL(1'b1), .KH(K), .KV(K)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .pat_i(pat),
        .hs_o(hs), .vs_o(vs), .de_o(de), .data_o(data),
        .x_o(x), .y_o(y), .sof_o(sof)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", n, a, e, $time);
        end
    endtask

    function automatic logic [23:0] pix(input int h, input int v, input int p);
        logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                  24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        int b;
        logic [7:0] r;
        if (!(h < HWID && v < VHEI)) return 24'h0;
        b = h / (HWID / 8);
        if (b > 7) b = 7;
        r = 8'(h);
        case (p)
            0: return bars[b];
            1: return (((h / K) + (v / K)) % 2 == 0) ? 24'hFFFFFF : 24'h000000;
            2: return {r, r, r};
            default: return 24'h808080;
        endcase
    endfunction

    int m_h = 0, m_v = 0, m_p = 0;
    logic e_de, e_sof, e_hs, e_vs, e_xyv;
    logic [23:0] e_d;
    logic [11:0] e_x, e_y;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_h <= 0; m_v <= 0; m_p <= 0;
            e_de <= 0; e_sof <= 0; e_d <= 0; e_x <= 0; e_y <= 0;
            e_hs <= 0; e_vs <= 0; e_xyv <= 1;
        end else if (!en) begin
            e_de <= 0; e_sof <= 0; e_d <= 0; e_hs <= 0; e_vs <= 0; e_xyv <= 0;
        end else begin
            e_de  <= (m_h < HWID && m_v < VHEI);
            e_sof <= (m_h == 0 && m_v == 0);
            e_x   <= 12'(m_h);
            e_y   <= 12'(m_v);
            e_xyv <= 1;
            e_hs  <= (m_h >= HST && m_h < HST + HSY);
            e_vs  <= (m_v >= VST && m_v < VST + VSY);
            e_d   <= pix(m_h, m_v, (m_h == 0 && m_v == 0) ? int'(pat) : m_p);
            if (m_h == 0 && m_v == 0) m_p <= int'(pat);
            m_h <= (m_h == HTOT - 1) ? 0 : m_h + 1;
            if (m_h == HTOT - 1) m_v <= (m_v == VTOT - 1) ? 0 : m_v + 1;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("model_de", 32'(de), 32'(e_de));
            chk("model_sof", 32'(sof), 32'(e_sof));
            chk("model_data", 32'(data), 32'(e_d));
            chk("model_hs", 32'(hs), 32'(e_hs));
            chk("model_vs", 32'(vs), 32'(e_vs));
            if (e_xyv) begin
                chk("model_x", 32'(x), 32'(e_x));
                chk("model_y", 32'(y), 32'(e_y));
            end
        end
    end

    task automatic wait_sof();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (sof) return;
        end
        chk("sof_timeout", 0, 1);
    endtask

    task automatic wait_xy(input int wx, input int wy);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (int'(x) == wx && int'(y) == wy && en) return;
        end
        chk("xy_timeout", 0, 1);
    endtask

    task automatic chk_reset_vals(input string n);
        chk({n, "_de"}, 32'(de), 0);
        chk({n, "_sof"}, 32'(sof), 0);
        chk({n, "_data"}, 32'(data), 0);
        chk({n, "_x"}, 32'(x), 0);
        chk({n, "_y"}, 32'(y), 0);
        chk({n, "_hs"}, 32'(hs), 0);
        chk({n, "_vs"}, 32'(vs), 0);
    endtask

    int per, des, hsn, hsbad, vsn, vsx, vsy;

    initial begin
        @(negedge clk);
        armed = 1'b1;
        @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_sof", 32'(sof), 1);
        // One full frame of bars: period, de count, sync placement.
        per = 0; des = 0; hsn = 0; hsbad = 0; vsn = 0; vsx = -1; vsy = -1;
        for (int i = 0; i < 500; i++) begin
            des += int'(de);
            if (hs) begin
                hsn++;
                if (x != 10 && x != 11) hsbad++;
            end
            if (vs) begin
                if (vsn == 0) begin vsx = int'(x); vsy = int'(y); end
                vsn++;
            end
            @(negedge clk);
            per++;
            if (sof) break;
        end
        chk("frame_period", per, 98);
        chk("de_per_frame", des, 32);
        chk("hs_count", hsn, 14);
        chk("hs_misplaced", hsbad, 0);
        chk("vs_count", vsn, 14);
        chk("vs_rise_x", vsx, 0);
        chk("vs_rise_y", vsy, 5);
        // Checkerboard selected mid-frame; takes effect at the next frame.
        pat = 2'd1;
        wait_sof();
        chk("chk_l0_x0", 32'(data), 32'hFFFFFF);
        @(negedge clk); chk("chk_l0_x1", 32'(data), 32'hFFFFFF);
        @(negedge clk); chk("chk_l0_x2", 32'(data), 32'h000000);
        @(negedge clk); chk("chk_l0_x3", 32'(data), 32'h000000);
        wait_xy(0, 2); chk("chk_l2_x0", 32'(data), 32'h000000);
        @(negedge clk); chk("chk_l2_x1", 32'(data), 32'h000000);
        @(negedge clk); chk("chk_l2_x2", 32'(data), 32'hFFFFFF);
        // Bars frame, then switch to ramp at h=3 of line 1.
        pat = 2'd0;
        wait_sof();
        wait_xy(3, 1);
        pat = 2'd2;
        wait_xy(1, 2); chk("bars_persist", 32'(data), 32'hFFFF00);
        wait_sof(); chk("ramp_x0", 32'(data), 32'h000000);
        wait_xy(7, 0); chk("ramp_x7", 32'(data), 32'h070707);
        // Freeze 20 cycles with the counter at h=5, v=2.
        wait_sof();
        per = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            per++;
            if (x == 4 && y == 2) break;
        end
        en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            per++;
        end
        chk("frozen_de", 32'(de), 0);
        chk("frozen_hs", 32'(hs), 0);
        en = 1'b1;
        @(negedge clk);
        per++;
        chk("resume_x", 32'(x), 5);
        chk("resume_y", 32'(y), 2);
        chk("resume_de", 32'(de), 1);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            per++;
            if (sof) break;
        end
        chk("frozen_period", per, 118);
        // One-cycle reset in the middle of line 3.
        wait_xy(2, 3);
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_vals("midreset");
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_sof", 32'(sof), 1);
        chk("post_reset_x", 32'(x), 0);
        chk("post_reset_y", 32'(y), 0);
        repeat (20) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
